execute_stage: RTL and testbench
================================

# execute_stage

Execute (E) stage of the five-stage MIPS pipeline. Consumes the D2E pipeline registers from the decode stage and performs the ALU operation. Owns the HI/LO registers and a multi-cycle multiply/divide unit. Forwards from the M and W stages and drives the E2M pipeline registers, including `WhoNew_E2M` and `ALUout_E2M`, which decode reads back for its own forwarding.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

Ports:
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-low reset.
- `IR_D2E` in 32: instruction in E.
- `PC4_D2E` in 32: PC+4 of the instruction in E.
- `RD1_D2E` in 32: rs value from decode.
- `RD2_D2E` in 32: rt value from decode.
- `IMM_D2E` in 32: immediate already extended by decode. Holds PC+8 for jal and the upper-loaded value for lui.
- `A3` in 5: W-stage write register.
- `WD2A3` in 32: W-stage write data.
- `WriteEnabled` in 1: W-stage write enable.
- `IR_E2M` out 32: registered copy of `IR_D2E`.
- `PC4_E2M` out 32: registered copy of `PC4_D2E`.
- `ALUout_E2M` out 32: registered result or memory address.
- `RD2_E2M` out 32: registered forwarded rt, used as store data.
- `WhoNew_E2M` out 5: registered destination whose final value is `ALUout_E2M`. 0 if none.
- `Busy_E` out 1: combinational; the upstream stall logic consumes it.

## Operation
- **Forwarding** for rs (`IR_D2E[25:21]`) and rt (`IR_D2E[20:16]`), first match wins:
  - If the register equals `WhoNew_E2M` and is nonzero, use `ALUout_E2M`.
  - Else if it equals `A3`, is nonzero and `WriteEnabled`=1, use `WD2A3`.
  - Else use `RD1_D2E` / `RD2_D2E`.
  - Forwarded values are called FA (rs) and FB (rt) below.
- **SPECIAL (op 000000)**, results to rd:
  - addu 100001: FA+FB.
  - subu 100011: FA-FB.
  - and 100100, or 100101.
  - slt 101010: signed compare; sltu 101011: unsigned compare.
  - sll 000000, srl 000010, sra 000011: FB shifted by `IR[10:6]`.
  - mfhi 010000: HI. mflo 010010: LO.
- **I-type**, results to rt:
  - ori 001101: FA|IMM.
  - addiu 001001: FA+IMM.
  - lui 001111: IMM.
- **Jump/link:** jal 000011 gives ALUout=IMM, destination 31.
- **Memory:** lw 100011 and sw 101011 give ALUout=FA+IMM; `WhoNew_E2M` is 0 for both.
- **No result:** jr, beq, mult/div, mthi/mtlo and all other encodings give ALUout=0 and `WhoNew_E2M`=0.
- **Destination rule:** `WhoNew_E2M` is forced to 0 when the destination is $0.
- **Wrap-around:** all arithmetic is 32-bit and wraps; no overflow exceptions.
- **Mul/div state machine**, states IDLE and BUSY, with a 4-bit down-counter `cnt`:
  - `start` = (state IDLE) and the instruction in E is mult 011000, multu 011001, div 011010 or divu 011011.
  - IDLE→BUSY on `start`. Operands FA/FB and the operation are latched. `cnt` loads MULT_CYCLES or DIV_CYCLES.
  - In BUSY, `cnt` decrements each cycle. On the edge where `cnt`==1, HI/LO are written and the state returns to IDLE.
  - mult/multu: {HI,LO} = 64-bit signed or unsigned product.
  - div/divu: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
  - Divisor 0: LO=0xFFFFFFFF, HI=dividend.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - mthi 010001 / mtlo 010011 in IDLE: HI/LO ← FA at the edge.
- **Busy_E** = `start` | (state==BUSY).
  - While `Busy_E` is high, upstream holds any mult/div/mfhi/mflo/mthi/mtlo in D and feeds a nop into E.
  - A md instruction arriving in E while BUSY is a protocol violation and is ignored.
- **E2M registers** update every edge; there is no stall input.

## Timing
- **Reset** (asynchronous, `Reset`=0):
  - All E2M outputs = 0, HI = LO = 0.
  - State = IDLE, `cnt` = 0, so `Busy_E` = 0 unless a md instruction is present.
  - A reset mid-operation aborts it; HI/LO are not written.
- **ALU path:** single cycle. The result appears on `ALUout_E2M` one edge after the instruction is in E.
- **Multiply:** `Busy_E` is high for 1 + MULT_CYCLES consecutive cycles (the `start` cycle plus BUSY).
  - HI/LO are valid from the edge that ends BUSY.
  - mfhi entering E in the first IDLE cycle reads the new value.
- **Divide:** `Busy_E` is high for 1 + DIV_CYCLES cycles.
- **Same-edge mthi and BUSY completion:** cannot occur, because of the stall protocol.
- **Forwarding** is combinational within the E cycle. The M source takes priority over W when both match.

## Test plan
1. **Reset:** Reset low mid-div (`cnt`=4) → outputs, HI and LO = 0 immediately; `Busy_E`=0 after release.
2. **Forwarding:** addu $8,$0,$0 with RD=5/7 and `WhoNew_E2M`=8, `ALUout_E2M`=3; next instruction addu $9,$8,$8 → `ALUout_E2M`=6, `WhoNew_E2M`=9. With M and W both matching $8 (W data 9), M wins.
3. **Signed mult:** mult with FA=0xFFFFFFFF, FB=2 → `Busy_E` high 6 cycles; then mfhi gives 0xFFFFFFFF and mflo gives 0xFFFFFFFE. Same operands with multu → HI=0x00000001, LO=0xFFFFFFFE.
4. **Divide:** div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, with `Busy_E` high 11 cycles. divu 7/2 → LO=3, HI=1.
5. **Divide edge cases:** divu 5/0 → LO=0xFFFFFFFF, HI=5. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
6. **Link, loads and $0:**
   - jal with IMM=0x3010 → `ALUout_E2M`=0x3010, `WhoNew_E2M`=31.
   - lw base 0x100, imm 4 → `ALUout_E2M`=0x104, `WhoNew_E2M`=0.
   - addu $0,… → `WhoNew_E2M`=0.

Source files
------------

// File: rtl/execute_stage_if.sv
// Execute-stage bus: D2E pipeline inputs, W-stage write-back snoop,
// E2M pipeline outputs and the mul/div busy flag.
interface execute_stage_if;
  logic [31:0] IR_D2E;
  logic [31:0] PC4_D2E;
  logic [31:0] RD1_D2E;
  logic [31:0] RD2_D2E;
  logic [31:0] IMM_D2E;
  logic [4:0]  A3;
  logic [31:0] WD2A3;
  logic        WriteEnabled;
  logic [31:0] IR_E2M;
  logic [31:0] PC4_E2M;
  logic [31:0] ALUout_E2M;
  logic [31:0] RD2_E2M;
  logic [4:0]  WhoNew_E2M;
  logic        Busy_E;

  // Upstream side: decode/write-back drive, pipeline results come back.
  modport master (
    output IR_D2E, PC4_D2E, RD1_D2E, RD2_D2E, IMM_D2E,
    output A3, WD2A3, WriteEnabled,
    input  IR_E2M, PC4_E2M, ALUout_E2M, RD2_E2M, WhoNew_E2M, Busy_E
  );

  // Execute stage side.
  modport slave (
    input  IR_D2E, PC4_D2E, RD1_D2E, RD2_D2E, IMM_D2E,
    input  A3, WD2A3, WriteEnabled,
    output IR_E2M, PC4_E2M, ALUout_E2M, RD2_E2M, WhoNew_E2M, Busy_E
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: operand forwarding from M/W, single-cycle ALU,
// HI/LO registers with a multi-cycle multiply/divide unit, and the E2M
// pipeline registers.
module execute_stage #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic            Clk,
  input logic            Reset,
  execute_stage_if.slave bus
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MTLO = 6'b010011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Latched md operation is funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu.
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Instruction fields
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] shamt;
  logic [5:0] funct;

  assign op    = bus.IR_D2E[31:26];
  assign rs    = bus.IR_D2E[25:21];
  assign rt    = bus.IR_D2E[20:16];
  assign rd    = bus.IR_D2E[15:11];
  assign shamt = bus.IR_D2E[10:6];
  assign funct = bus.IR_D2E[5:0];

  logic [31:0] fa;
  logic [31:0] fb;

  logic        is_md_op;
  logic        is_mthi;
  logic        is_mtlo;
  logic        md_start;
  logic        md_done;
  logic        busy;

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  md_op_q, md_op_d;
  logic [31:0] md_a_q, md_a_d;
  logic [31:0] md_b_q, md_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] alu_result;
  logic [4:0]  alu_dest;

  logic [31:0] ir_e2m_q, ir_e2m_d;
  logic [31:0] pc4_e2m_q, pc4_e2m_d;
  logic [31:0] alu_e2m_q, alu_e2m_d;
  logic [31:0] rd2_e2m_q, rd2_e2m_d;
  logic [4:0]  who_e2m_q, who_e2m_d;

  // Operand forwarding: the M-stage result beats the W-stage write-back, $0 never forwards.
  always_comb begin
    fa = bus.RD1_D2E;
    if ((rs != 5'd0) && (rs == who_e2m_q)) begin
      fa = alu_e2m_q;
    end else if ((rs != 5'd0) && bus.WriteEnabled && (rs == bus.A3)) begin
      fa = bus.WD2A3;
    end

    fb = bus.RD2_D2E;
    if ((rt != 5'd0) && (rt == who_e2m_q)) begin
      fb = alu_e2m_q;
    end else if ((rt != 5'd0) && bus.WriteEnabled && (rt == bus.A3)) begin
      fb = bus.WD2A3;
    end
  end

  assign is_md_op = (op == OP_SPECIAL) && (funct[5:2] == 4'b0110);
  assign is_mthi  = (op == OP_SPECIAL) && (funct == FN_MTHI);
  assign is_mtlo  = (op == OP_SPECIAL) && (funct == FN_MTLO);

  // Mul/div FSM outputs: start pulse, completion strobe and the stall request.
  always_comb begin
    md_start = (state_q == MD_IDLE) && is_md_op;
    md_done  = (state_q == MD_BUSY) && (cnt_q == 4'd1);
    busy     = md_start || (state_q == MD_BUSY);
  end

  assign bus.Busy_E = busy;

  // Mul/div FSM next state: latch operands on start, count down while busy.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    md_a_d  = md_a_q;
    md_b_d  = md_b_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = funct[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          md_op_d = funct[1:0];
          md_a_d  = fa;
          md_b_d  = fb;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Multiply/divide datapath on the latched operands; divide works on magnitudes
  // so that the most-negative / -1 case falls out without overflow.
  logic        md_signed;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] mag_b_safe;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quotient;
  logic [31:0] remainder;

  always_comb begin
    md_signed  = ~md_op_q[0];
    ext_a      = {{32{md_signed & md_a_q[31]}}, md_a_q};
    ext_b      = {{32{md_signed & md_b_q[31]}}, md_b_q};
    product    = ext_a * ext_b;
    neg_a      = md_signed & md_a_q[31];
    neg_b      = md_signed & md_b_q[31];
    mag_a      = neg_a ? (32'd0 - md_a_q) : md_a_q;
    mag_b      = neg_b ? (32'd0 - md_b_q) : md_b_q;
    mag_b_safe = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quot_mag   = mag_a / mag_b_safe;
    rem_mag    = mag_a % mag_b_safe;
    quotient   = (neg_a ^ neg_b) ? (32'd0 - quot_mag) : quot_mag;
    remainder  = neg_a ? (32'd0 - rem_mag) : rem_mag;
  end

  // HI/LO update: md completion writes both, mthi/mtlo write one while idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_done) begin
      if ((md_op_q == MD_MULT) || (md_op_q == MD_MULTU)) begin
        hi_d = product[63:32];
        lo_d = product[31:0];
      end else if (md_b_q == 32'd0) begin
        hi_d = md_a_q;
        lo_d = 32'hFFFF_FFFF;
      end else begin
        hi_d = remainder;
        lo_d = quotient;
      end
    end else if (state_q == MD_IDLE) begin
      if (is_mthi) begin
        hi_d = fa;
      end
      if (is_mtlo) begin
        lo_d = fa;
      end
    end
  end

  // Mul/div state register, including HI/LO; reset aborts any operation.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      md_op_q <= MD_MULT;
      md_a_q  <= 32'd0;
      md_b_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
      md_a_q  <= md_a_d;
      md_b_q  <= md_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Single-cycle ALU and destination select; instructions without a register result yield 0/0.
  always_comb begin
    alu_result = 32'd0;
    alu_dest   = 5'd0;
    case (op)
      OP_SPECIAL: begin
        alu_dest = rd;
        case (funct)
          FN_ADDU: alu_result = fa + fb;
          FN_SUBU: alu_result = fa - fb;
          FN_AND:  alu_result = fa & fb;
          FN_OR:   alu_result = fa | fb;
          FN_SLT:  alu_result = {31'd0, ($signed(fa) < $signed(fb))};
          FN_SLTU: alu_result = {31'd0, (fa < fb)};
          FN_SLL:  alu_result = fb << shamt;
          FN_SRL:  alu_result = fb >> shamt;
          FN_SRA:  alu_result = $unsigned($signed(fb) >>> shamt);
          FN_MFHI: alu_result = hi_q;
          FN_MFLO: alu_result = lo_q;
          default: alu_dest = 5'd0;
        endcase
      end
      OP_ORI: begin
        alu_result = fa | bus.IMM_D2E;
        alu_dest   = rt;
      end
      OP_ADDIU: begin
        alu_result = fa + bus.IMM_D2E;
        alu_dest   = rt;
      end
      OP_LUI: begin
        alu_result = bus.IMM_D2E;
        alu_dest   = rt;
      end
      OP_JAL: begin
        alu_result = bus.IMM_D2E;
        alu_dest   = 5'd31;
      end
      OP_LW, OP_SW: begin
        alu_result = fa + bus.IMM_D2E;
      end
      default: begin
        alu_result = 32'd0;
        alu_dest   = 5'd0;
      end
    endcase
  end

  // E2M next values; writes to $0 never advertise a destination.
  always_comb begin
    ir_e2m_d  = bus.IR_D2E;
    pc4_e2m_d = bus.PC4_D2E;
    alu_e2m_d = alu_result;
    rd2_e2m_d = fb;
    who_e2m_d = alu_dest;
  end

  // E2M pipeline registers advance on every edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir_e2m_q  <= 32'd0;
      pc4_e2m_q <= 32'd0;
      alu_e2m_q <= 32'd0;
      rd2_e2m_q <= 32'd0;
      who_e2m_q <= 5'd0;
    end else begin
      ir_e2m_q  <= ir_e2m_d;
      pc4_e2m_q <= pc4_e2m_d;
      alu_e2m_q <= alu_e2m_d;
      rd2_e2m_q <= rd2_e2m_d;
      who_e2m_q <= who_e2m_d;
    end
  end

  assign bus.IR_E2M     = ir_e2m_q;
  assign bus.PC4_E2M    = pc4_e2m_q;
  assign bus.ALUout_E2M = alu_e2m_q;
  assign bus.RD2_E2M    = rd2_e2m_q;
  assign bus.WhoNew_E2M = who_e2m_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: reset, forwarding, ALU ops,
// multiply/divide timing and results, link/load/store and $0 handling.
module tb_execute_stage;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;
  logic [31:0] pcNext;

  execute_stage_if bus ();

  execute_stage #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Drive one instruction into E and let combinational logic settle.
  task automatic applyStimulus(input logic [31:0] ir, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm);
    pcNext          = pcNext + 32'd4;
    bus.IR_D2E      = ir;
    bus.PC4_D2E     = pcNext;
    bus.RD1_D2E     = rd1;
    bus.RD2_D2E     = rd2;
    bus.IMM_D2E     = imm;
    #1;
  endtask

  task automatic setWriteback(input logic [4:0] a3, input logic [31:0] wd, input logic we);
    bus.A3           = a3;
    bus.WD2A3        = wd;
    bus.WriteEnabled = we;
  endtask

  task automatic stepClock;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One ALU instruction: apply, clock, compare result and destination.
  task automatic aluStep(input string tag, input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] expAlu, input logic [4:0] expWho);
    applyStimulus(ir, a, b, imm);
    stepClock();
    checkOutput({tag, "_alu"}, bus.ALUout_E2M, expAlu);
    checkOutput({tag, "_who"}, {27'd0, bus.WhoNew_E2M}, {27'd0, expWho});
  endtask

  // One mul/div: count busy cycles with nops fed in, then read HI and LO.
  task automatic runMd(input string tag, input logic [5:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input int expCycles,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    n = 0;
    applyStimulus(rType(5'd1, 5'd2, 5'd0, 5'd0, fn), a, b, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (!bus.Busy_E) break;
      n++;
      stepClock();
      applyStimulus(NOP, 32'd0, 32'd0, 32'd0);
    end
    checkOutput({tag, "_busy_cycles"}, 32'(n), 32'(expCycles));
    applyStimulus(rType(5'd0, 5'd0, 5'd3, 5'd0, 6'b010000), 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput({tag, "_hi"}, bus.ALUout_E2M, expHi);
    applyStimulus(rType(5'd0, 5'd0, 5'd4, 5'd0, 6'b010010), 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput({tag, "_lo"}, bus.ALUout_E2M, expLo);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    pcNext   = 32'h0000_3000;
    Reset    = 1'b0;
    setWriteback(5'd0, 32'd0, 1'b0);
    applyStimulus(NOP, 32'd0, 32'd0, 32'd0);

    // Reset state
    checkOutput("rst_alu", bus.ALUout_E2M, 32'd0);
    checkOutput("rst_who", {27'd0, bus.WhoNew_E2M}, 32'd0);
    checkOutput("rst_ir", bus.IR_E2M, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.Busy_E}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    stepClock();

    // mthi then mfhi, so HI is known nonzero before the mid-divide reset
    applyStimulus(rType(5'd1, 5'd0, 5'd0, 5'd0, 6'b010001), 32'h55, 32'd0, 32'd0);
    stepClock();
    applyStimulus(rType(5'd0, 5'd0, 5'd3, 5'd0, 6'b010000), 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput("mthi_mfhi", bus.ALUout_E2M, 32'h55);

    // Start a divide, run into BUSY, then reset with cnt at 4
    applyStimulus(rType(5'd1, 5'd2, 5'd0, 5'd0, 6'b011010), 32'd100, 32'd7, 32'd0);
    checkOutput("div_start_busy", {31'd0, bus.Busy_E}, 32'd1);
    stepClock();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(iType(6'b001001, 5'd0, 5'd2, 16'h1234), 32'd0, 32'd0, 32'h1234);
      stepClock();
    end
    checkOutput("mid_div_busy", {31'd0, bus.Busy_E}, 32'd1);
    checkOutput("mid_div_alu", bus.ALUout_E2M, 32'h1234);
    Reset = 1'b0;
    #1;
    checkOutput("rst_async_alu", bus.ALUout_E2M, 32'd0);
    checkOutput("rst_async_who", {27'd0, bus.WhoNew_E2M}, 32'd0);
    checkOutput("rst_async_ir", bus.IR_E2M, 32'd0);
    checkOutput("rst_async_pc4", bus.PC4_E2M, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus(NOP, 32'd0, 32'd0, 32'd0);
    checkOutput("rst_release_busy", {31'd0, bus.Busy_E}, 32'd0);
    stepClock();
    applyStimulus(rType(5'd0, 5'd0, 5'd3, 5'd0, 6'b010000), 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput("rst_hi_cleared", bus.ALUout_E2M, 32'd0);
    applyStimulus(rType(5'd0, 5'd0, 5'd4, 5'd0, 6'b010010), 32'd0, 32'd0, 32'd0);
    stepClock();
    checkOutput("rst_lo_cleared", bus.ALUout_E2M, 32'd0);

    // Forwarding from M, M over W, W alone, and W disabled
    aluStep("fwd_src", iType(6'b001001, 5'd0, 5'd8, 16'd3), 32'd0, 32'd0, 32'd3, 32'd3, 5'd8);
    aluStep("fwd_m", rType(5'd8, 5'd8, 5'd9, 5'd0, 6'b100001), 32'd5, 32'd7, 32'd0, 32'd6, 5'd9);
    checkOutput("fwd_m_rd2", bus.RD2_E2M, 32'd3);
    aluStep("fwd_src2", iType(6'b001001, 5'd0, 5'd8, 16'd3), 32'd0, 32'd0, 32'd3, 32'd3, 5'd8);
    setWriteback(5'd8, 32'd9, 1'b1);
    aluStep("fwd_m_beats_w", rType(5'd8, 5'd8, 5'd9, 5'd0, 6'b100001), 32'd5, 32'd7, 32'd0, 32'd6, 5'd9);
    aluStep("fwd_w", rType(5'd8, 5'd8, 5'd10, 5'd0, 6'b100001), 32'd5, 32'd7, 32'd0, 32'd18, 5'd10);
    setWriteback(5'd8, 32'd9, 1'b0);
    aluStep("fwd_w_disabled", rType(5'd8, 5'd8, 5'd11, 5'd0, 6'b100001), 32'd5, 32'd7, 32'd0, 32'd12, 5'd11);
    setWriteback(5'd0, 32'd0, 1'b0);

    // ALU operations
    aluStep("subu", rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100011), 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 5'd3);
    aluStep("and", rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100100), 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0, 32'h00F0_F000, 5'd3);
    aluStep("or", rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100101), 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'd0, 32'hFFF0_FFF0, 5'd3);
    aluStep("slt", rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b101010), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 5'd3);
    aluStep("sltu", rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b101011), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
    aluStep("sll", rType(5'd0, 5'd2, 5'd3, 5'd4, 6'b000000), 32'd0, 32'h81, 32'd0, 32'h810, 5'd3);
    aluStep("srl", rType(5'd0, 5'd2, 5'd3, 5'd4, 6'b000010), 32'd0, 32'h8000_0000, 32'd0, 32'h0800_0000, 5'd3);
    aluStep("sra", rType(5'd0, 5'd2, 5'd3, 5'd4, 6'b000011), 32'd0, 32'h8000_0000, 32'd0, 32'hF800_0000, 5'd3);
    aluStep("addu_wrap", rType(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001), 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd1, 5'd3);
    aluStep("ori", iType(6'b001101, 5'd1, 5'd4, 16'h0034), 32'h1200, 32'd0, 32'h34, 32'h1234, 5'd4);
    aluStep("addiu_wrap", iType(6'b001001, 5'd1, 5'd5, 16'h0001), 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd5);
    aluStep("lui", iType(6'b001111, 5'd0, 5'd6, 16'h1234), 32'd0, 32'd0, 32'h1234_0000, 32'h1234_0000, 5'd6);

    // Link, memory, $0 destination and no-result encodings
    aluStep("jal", {6'b000011, 26'h0000C04}, 32'd0, 32'd0, 32'h3010, 32'h3010, 5'd31);
    checkOutput("jal_ir", bus.IR_E2M, {6'b000011, 26'h0000C04});
    checkOutput("jal_pc4", bus.PC4_E2M, pcNext);
    aluStep("lw", iType(6'b100011, 5'd1, 5'd5, 16'd4), 32'h100, 32'd0, 32'd4, 32'h104, 5'd0);
    aluStep("sw", iType(6'b101011, 5'd1, 5'd5, 16'd8), 32'h100, 32'hABCD, 32'd8, 32'h108, 5'd0);
    checkOutput("sw_data", bus.RD2_E2M, 32'hABCD);
    aluStep("addu_r0", rType(5'd1, 5'd2, 5'd0, 5'd0, 6'b100001), 32'd5, 32'd7, 32'd0, 32'd12, 5'd0);
    aluStep("beq", iType(6'b000100, 5'd1, 5'd2, 16'd8), 32'd5, 32'd5, 32'd8, 32'd0, 5'd0);
    aluStep("jr", rType(5'd1, 5'd0, 5'd0, 5'd0, 6'b001000), 32'h4000, 32'd0, 32'd0, 32'd0, 5'd0);

    // Multiply and divide
    runMd("mult", 6'b011000, 32'hFFFF_FFFF, 32'd2, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runMd("multu", 6'b011001, 32'hFFFF_FFFF, 32'd2, 6, 32'h0000_0001, 32'hFFFF_FFFE);
    runMd("div_neg", 6'b011010, 32'hFFFF_FFF9, 32'd2, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runMd("divu", 6'b011011, 32'd7, 32'd2, 11, 32'd1, 32'd3);
    runMd("divu_zero", 6'b011011, 32'd5, 32'd0, 11, 32'd5, 32'hFFFF_FFFF);
    runMd("div_ovf", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 11, 32'd0, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
